// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle SLL/SRL/SRA/ROR unit for the MIPS datapath.
// Shifts up to STEP positions per clock; result and carry held in registers.
module seq_shift_unit #(
    parameter int n    = 32,
    parameter int STEP = 1,
    localparam int SHW = $clog2(n)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [n-1:0]   data_in,
    input  logic [SHW-1:0] shamt,
    output logic           busy,
    output logic           done,
    output logic [n-1:0]   data_out,
    output logic           carry_out
);

    localparam int CW   = SHW + 1;
    // rem never exceeds n-1, so step sizes beyond that are unreachable
    localparam int KMAX = (STEP < n) ? STEP : n - 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   work_q, work_d;
    logic [SHW-1:0] rem_q, rem_d;
    logic [1:0]     op_q, op_d;
    logic           sign_q, sign_d;
    logic           carry_q, carry_d;
    logic [n-1:0]   dout_q, dout_d;
    logic           cout_q, cout_d;

    logic [SHW-1:0]        k;
    logic [KMAX:1][n-1:0]  cand;
    logic [KMAX:1]         cbit;
    logic [n-1:0]          step_w;
    logic                  step_c;

    assign k = ({1'b0, rem_q} < CW'(STEP)) ? rem_q : SHW'(KMAX);

    for (genvar j = 1; j <= KMAX; j++) begin : g_step
        logic [n-1:0] sll_w, srl_w, sra_w, ror_w;
        assign sll_w = work_q << j;
        assign srl_w = work_q >> j;
        assign sra_w = srl_w | ({n{sign_q}} << (n - j));
        assign ror_w = srl_w | (work_q << (n - j));
        assign cand[j] = (op_q == OP_SLL) ? sll_w :
                         (op_q == OP_SRL) ? srl_w :
                         (op_q == OP_SRA) ? sra_w : ror_w;
        assign cbit[j] = (op_q == OP_SLL) ? work_q[n-j] : work_q[j-1];
    end

    always_comb begin
        step_w = work_q;
        step_c = 1'b0;
        for (int j = 1; j <= KMAX; j++) begin
            if (k == SHW'(j)) begin
                step_w = cand[j];
                step_c = cbit[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        carry_d = carry_q;
        dout_d  = dout_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    work_d  = data_in;
                    op_d    = op;
                    rem_d   = shamt;
                    sign_d  = data_in[n-1];
                    carry_d = 1'b0;
                    if (shamt == '0) begin
                        state_d = S_DONE;
                        dout_d  = data_in;
                        cout_d  = 1'b0;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d  = step_w;
                carry_d = step_c;
                rem_d   = rem_q - k;
                if (rem_q == k) begin
                    state_d = S_DONE;
                    dout_d  = step_w;
                    cout_d  = step_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            carry_q <= carry_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
        end
    end

    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);
    assign data_out  = dout_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: one STEP=4 and one STEP=1 instance
// share operands; sel picks which one receives start and is observed.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;

    logic        busy4, done4, cout4;
    logic [31:0] dout4;
    logic        busy1, done1, cout1;
    logic [31:0] dout1;
    logic        start4, start1;
    logic        cbusy, cdone, ccout;
    logic [31:0] cdout;

    int total = 0;
    int bad = 0;
    logic [31:0] last4 = '0;
    logic [31:0] last1 = '0;

    always #5 clk = ~clk;

    assign start4 = start & ~sel;
    assign start1 = start & sel;
    assign cbusy  = sel ? busy1 : busy4;
    assign cdone  = sel ? done1 : done4;
    assign ccout  = sel ? cout1 : cout4;
    assign cdout  = sel ? dout1 : dout4;

    seq_shift_unit #(.n(32), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start4), .op(op),
        .data_in(data_in), .shamt(shamt), .busy(busy4),
        .done(done4), .data_out(dout4), .carry_out(cout4)
    );

    seq_shift_unit #(.n(32), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start1), .op(op),
        .data_in(data_in), .shamt(shamt), .busy(busy1),
        .done(done1), .data_out(dout1), .carry_out(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one op and returns during its done cycle.
    task automatic run_op(input string tag, input logic s1,
                          input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] sh, input logic [31:0] ed,
                          input logic ec, input int ecyc, input int inj);
        int nb;
        int guard;
        logic [31:0] prev;
        prev = s1 ? last1 : last4;
        sel = s1;
        op = o;
        data_in = d;
        shamt = sh;
        start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        guard = 0;
        while (!cdone && guard < 100) begin
            if (cbusy) begin
                nb++;
                if (nb == 1) chk({tag, " hold"}, cdout, prev);
                if (nb == inj) begin
                    start = 1'b1;
                    op = 2'b00;
                    data_in = 32'hAAAA_5555;
                    shamt = 5'd1;
                end else begin
                    start = 1'b0;
                end
            end
            tick();
            guard++;
        end
        start = 1'b0;
        chk({tag, " timeout"}, 32'(guard < 100), 32'd1);
        chk({tag, " excl"}, {31'b0, cbusy & cdone}, 32'd0);
        chk({tag, " cycles"}, 32'(nb), 32'(ecyc));
        chk({tag, " data"}, cdout, ed);
        chk({tag, " carry"}, {31'b0, ccout}, {31'b0, ec});
        if (s1) last1 = ed;
        else last4 = ed;
    endtask

    task automatic idle_chk(input string tag);
        tick();
        chk({tag, " done_clr"}, {31'b0, cdone}, 32'd0);
        chk({tag, " idle"}, {31'b0, cbusy}, 32'd0);
    endtask

    initial begin
        int nd;
        tick();
        tick();
        chk("rst busy4", {31'b0, busy4}, 32'd0);
        chk("rst done4", {31'b0, done4}, 32'd0);
        chk("rst dout4", dout4, 32'd0);
        chk("rst busy1", {31'b0, busy1}, 32'd0);
        chk("rst dout1", dout1, 32'd0);
        chk("rst cout1", {31'b0, cout1}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("sll31", 1'b1, 2'b00, 32'h0000_0001, 5'd31,
               32'h8000_0000, 1'b0, 31, 0);
        idle_chk("sll31");

        run_op("sra4", 1'b0, 2'b10, 32'h8000_00F0, 5'd4,
               32'hF800_000F, 1'b0, 1, 0);
        idle_chk("sra4");

        run_op("srl5", 1'b0, 2'b01, 32'h0000_00FF, 5'd5,
               32'h0000_0007, 1'b1, 2, 0);
        idle_chk("srl5");

        run_op("ror8", 1'b0, 2'b11, 32'h1234_5678, 5'd8,
               32'h7812_3456, 1'b0, 2, 0);
        run_op("b2b", 1'b0, 2'b00, 32'hDEAD_BEEF, 5'd0,
               32'hDEAD_BEEF, 1'b0, 0, 0);
        idle_chk("b2b");

        run_op("sll1c", 1'b0, 2'b00, 32'hF000_0000, 5'd1,
               32'hE000_0000, 1'b1, 1, 0);
        idle_chk("sll1c");

        run_op("sll7", 1'b0, 2'b00, 32'h0000_0001, 5'd7,
               32'h0000_0080, 1'b0, 2, 0);
        idle_chk("sll7");

        run_op("sra31", 1'b0, 2'b10, 32'h7FFF_FFFF, 5'd31,
               32'h0000_0000, 1'b1, 8, 0);
        idle_chk("sra31");

        run_op("ror1", 1'b1, 2'b11, 32'h0000_0001, 5'd1,
               32'h8000_0000, 1'b1, 1, 0);
        idle_chk("ror1");

        run_op("ign", 1'b1, 2'b01, 32'h0000_0F00, 5'd10,
               32'h0000_0003, 1'b1, 10, 3);
        idle_chk("ign");

        sel = 1'b1;
        op = 2'b00;
        data_in = 32'h0000_0001;
        shamt = 5'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last1 = '0;
        last4 = '0;
        chk("abort busy", {31'b0, busy1}, 32'd0);
        chk("abort done", {31'b0, done1}, 32'd0);
        chk("abort dout", dout1, 32'd0);
        chk("abort cout", {31'b0, cout1}, 32'd0);
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (done1 || busy1) nd++;
            tick();
        end
        chk("abort quiet", 32'(nd), 32'd0);

        sel = 1'b0;
        op = 2'b00;
        data_in = 32'h0000_FFFF;
        shamt = 5'd3;
        start = 1'b1;
        rst = 1'b1;
        tick();
        chk("rs busy", {31'b0, busy4}, 32'd0);
        chk("rs done", {31'b0, done4}, 32'd0);
        chk("rs dout", dout4, 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("rs idle", {31'b0, busy4 | done4}, 32'd0);

        run_op("fresh", 1'b0, 2'b01, 32'h8000_0000, 5'd4,
               32'h0800_0000, 1'b0, 1, 0);
        idle_chk("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle, parametrised shift/rotate unit for the extended MIPS datapath; executes SLL/SRL/SRA/ROR with a variable shift amount.
- Shifts STEP bit positions per clock, trading latency against area, instead of using a full barrel shifter.
- Adds to the plain load/shift register: start/busy/done handshake, arithmetic fill, rotate, a carry/shift-out flag, and a result register that is held stable.

Parameters:
- n, 32, data width in bits (n >= 2).
- STEP, 1, maximum bit positions shifted per clock (1 <= STEP <= n).
- SHW, $clog2(n), shift-amount width. Derived localparam; not overridable.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- data_in  input  n  operand; captured on the accepting edge.
- shamt  input  SHW  shift amount 0..n-1; captured on the accepting edge.
- busy  output  1  high while the unit is in SHIFT.
- done  output  1  one-cycle pulse; result valid.
- data_out  output  n  result register; holds the last result.
- carry_out  output  1  last bit shifted (or rotated) out.

Behaviour:
- Reset (rst=1 at a rising edge) has priority over everything, including start:
  - state returns to IDLE;
  - busy=0, done=0, data_out=0, carry_out=0;
  - internal work register and remaining count are cleared;
  - an in-flight operation is abandoned and produces no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - latch data_in into the work register; latch op and shamt; rem=shamt;
  - capture sign = data_in[n-1];
  - if shamt=0, go to DONE; otherwise go to SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, rem); shift the work register by k per op; rem -= k;
  - carry register = last bit exiting in this step:
    - SLL: w[n-k];
    - SRL/SRA/ROR: w[k-1];
  - when rem reaches 0, go to DONE.
- Fill rules:
  - SLL: zeros into the LSBs.
  - SRL: zeros into the MSBs.
  - SRA: captured sign into the MSBs.
  - ROR: bits exiting the LSB re-enter at the MSB.
  - A partial final step (k < STEP) uses exactly k positions.
- Entry into DONE (same edge):
  - data_out <= final work register;
  - carry_out <= carry register, or 0 when shamt=0.
- DONE:
  - done=1 for exactly one cycle;
  - start=1 here is accepted as if in IDLE (back-to-back);
  - otherwise go to IDLE.
- Latency:
  - N = ceil(shamt/STEP) SHIFT cycles; done is high in the cycle after the N-th edge following the accepting edge.
  - shamt=0: done is high in the cycle right after the accepting edge.
  - Back-to-back throughput: one op per N+1 cycles.
- busy=1 exactly in SHIFT; busy and done are never high together.
- start in SHIFT is ignored: not queued, no effect on the operation in progress.
- data_out and carry_out change only on reset or on entry to DONE; they are stable in IDLE, SHIFT and DONE otherwise.
- The data_in, op and shamt inputs are don't-care except on the accepting edge.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- n=32, STEP=1: SLL, data_in=0x0000_0001, shamt=31 -> busy high 31 cycles, done pulse, data_out=0x8000_0000, carry_out=0.
- n=32, STEP=4: SRA, data_in=0x8000_00F0, shamt=4 -> 1 SHIFT cycle, data_out=0xF800_000F, carry_out=0.
- n=32, STEP=4: SRL, data_in=0x0000_00FF, shamt=5 -> steps of 4 then 1; done after 2 SHIFT cycles; data_out=0x0000_0007, carry_out=1.
- n=32, STEP=4: ROR, data_in=0x1234_5678, shamt=8 -> data_out=0x7812_3456, carry_out=0. Then start SLL shamt=0 with data_in=0xDEAD_BEEF during the DONE cycle -> accepted back-to-back; done next cycle with data_out=0xDEAD_BEEF, carry_out=0.
- STEP=1: SRL shamt=10 in progress, start pulsed with new operands at cycle 3 -> ignored; original result delivered at cycle 10. Then start a new op and assert rst at cycle 2 -> next cycle busy=0, done=0, data_out=0; no done pulse follows.
- rst=1 and start=1 on the same edge -> unit stays in IDLE, all outputs 0; after release, a fresh start=1 runs normally.
